spi_tx_sequencer: RTL and testbench

- Upstream feeder for the SPI master/slave top level.
- Accepts parallel bytes on a valid/ready interface and buffers them in a small FIFO.
- Serialises each byte MSB-first onto the top level's serial data input, framing each byte with an active-low chip-select.
- Enforces chip-select setup time, per-bit hold time and an inter-frame gap; reports frame completion and a frame count.

---
 rtl/spi_tx_pkg.sv | 18 +
 rtl/spi_byte_fifo.sv | 68 ++++++
 rtl/spi_tx_sequencer.sv | 129 ++++++++++++
 tb/tb_spi_tx_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_tx_pkg.sv
// Shared types and sizing helpers for the SPI transmit sequencer.
package spi_tx_pkg;

   localparam int unsigned DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      GAP
   } state_t;

   // Bits needed for a counter that runs 0 .. n-1 (never narrower than 1).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_byte_fifo.sv
// Small synchronous byte FIFO with occupancy counter and synchronous flush.
module spi_byte_fifo
   import spi_tx_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] din,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] dout
);

   localparam int unsigned AW       = cnt_w(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              do_push;
   logic              do_pop;

   // A full FIFO refuses pushes even when a pop happens on the same edge.
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy tracking; flush discards everything still queued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spi_tx_sequencer.sv
// Buffers parallel bytes and serialises them MSB-first as chip-select framed SPI words.
module spi_tx_sequencer
   import spi_tx_pkg::*;
#(
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned SETUP_CYC    = 2,
   parameter int unsigned CLKS_PER_BIT = 8,
   parameter int unsigned GAP_CYC      = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic              flush,
   output logic              cs_out,
   output logic              data_out,
   output logic              busy,
   output logic              frame_done,
   output logic [15:0]       frame_count
);

   localparam int unsigned CYC_N =
      (SETUP_CYC > CLKS_PER_BIT) ? ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC)
                                 : ((CLKS_PER_BIT > GAP_CYC) ? CLKS_PER_BIT : GAP_CYC);
   localparam int unsigned CYC_W = cnt_w(CYC_N);
   localparam int unsigned BIT_W = cnt_w(DATA_W);

   localparam logic [CYC_W-1:0] SETUP_LAST = CYC_W'(SETUP_CYC - 1);
   localparam logic [CYC_W-1:0] BITP_LAST  = CYC_W'(CLKS_PER_BIT - 1);
   localparam logic [CYC_W-1:0] GAP_LAST   = CYC_W'(GAP_CYC - 1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic [BIT_W-1:0]  bit_cnt;
   logic [CYC_W-1:0]  cyc_cnt;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_dout;
   logic              push;
   logic              pop;

   assign wr_ready = !fifo_full && !flush;
   assign push     = wr_valid && wr_ready;
   assign pop      = (state == IDLE) && !fifo_empty;
   assign busy     = (state != IDLE) || !fifo_empty;

   spi_byte_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (wr_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (fifo_dout)
   );

   // Frame sequencer: the pop edge already drops cs_out and presents the MSB,
   // so the IDLE cycle is the extra chip-select-high cycle between frames.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         cyc_cnt     <= '0;
         cs_out      <= 1'b1;
         data_out    <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  shreg    <= fifo_dout;
                  cs_out   <= 1'b0;
                  data_out <= fifo_dout[DATA_W-1];
                  cyc_cnt  <= '0;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               if (cyc_cnt == SETUP_LAST) begin
                  cyc_cnt <= '0;
                  bit_cnt <= '0;
                  state   <= SHIFT;
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
               end
            end
            SHIFT: begin
               if (cyc_cnt == BITP_LAST) begin
                  cyc_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     cs_out      <= 1'b1;
                     data_out    <= 1'b0;
                     frame_done  <= 1'b1;
                     frame_count <= frame_count + 16'd1;
                     state       <= GAP;
                  end else begin
                     bit_cnt  <= bit_cnt + BIT_W'(1);
                     shreg    <= {shreg[DATA_W-2:0], 1'b0};
                     data_out <= shreg[DATA_W-2];
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
               end
            end
            GAP: begin
               if (cyc_cnt == GAP_LAST) begin
                  cyc_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Directed bench for spi_tx_sequencer: vector table of single frames plus multi-cycle sequences.
module tb_spi_tx_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic        flush;
   logic        cs_out;
   logic        data_out;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_count;

   int n_vec = 0;
   int n_err = 0;

   spi_tx_sequencer #(
      .DATA_W       (8),
      .FIFO_DEPTH   (4),
      .SETUP_CYC    (2),
      .CLKS_PER_BIT (8),
      .GAP_CYC      (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_data     (wr_data),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .flush       (flush),
      .cs_out      (cs_out),
      .data_out    (data_out),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] bits;
      int         len;
      int         stab;
      int         gap;
      logic       done;
   } frame_t;

   typedef struct {
      logic [7:0] data;
      logic [7:0] exp_bits;
      logic       exp_msb;
   } vec_t;

   frame_t frames[$];
   int     done_cnt = 0;

   // Line monitor: rebuilds each completed frame from cs_out/data_out.
   initial begin
      frame_t cur;
      bit     in_frame;
      int     hi_cnt;
      logic   prev;
      in_frame = 0;
      hi_cnt   = 0;
      prev     = 1'b0;
      cur      = '{bits: '0, len: 0, stab: 0, gap: 0, done: 1'b0};
      forever begin
         @(negedge clk);
         if (frame_done === 1'b1) done_cnt++;
         if (reset !== 1'b0) begin
            in_frame = 0;
            hi_cnt   = 0;
         end else if (cs_out === 1'b0) begin
            if (!in_frame) begin
               in_frame = 1;
               cur      = '{bits: '0, len: 0, stab: 0, gap: hi_cnt, done: 1'b0};
               prev     = data_out;
            end
            if (cur.len > 0 && data_out !== prev &&
                !(cur.len >= 10 && (cur.len - 2) % 8 == 0)) cur.stab++;
            if (cur.len >= 2 && (cur.len - 2) % 8 == 0) cur.bits = {cur.bits[6:0], data_out};
            prev = data_out;
            cur.len++;
         end else begin
            if (in_frame) begin
               cur.done = frame_done;
               frames.push_back(cur);
               in_frame = 0;
               hi_cnt   = 0;
            end
            hi_cnt++;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached, frames=%0d required finish", frames.size());
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      wr_valid = 1'b0;
      flush    = 1'b0;
      wr_data  = 'x;
      step();
      step();
      frames.delete();
      reset = 1'b0;
      step();
   endtask

   task automatic push1(input logic [7:0] b);
      wr_data  = b;
      wr_valid = 1'b1;
      step();
      wr_valid = 1'b0;
      wr_data  = 'x;
   endtask

   task automatic wait_frames(input string name, input int n, input int budget);
      int t = 0;
      while (frames.size() < n && t < budget) begin
         step();
         t++;
      end
      check({name, "_frames_seen"}, frames.size(), n);
   endtask

   task automatic wait_cs_low(input string name);
      int t = 0;
      while (cs_out !== 1'b0 && t < 200) begin
         step();
         t++;
      end
      check({name, "_cs_fell"}, cs_out, 1'b0);
   endtask

   task automatic wait_idle(input string name, input int exp_cycles);
      int t = 0;
      while (busy !== 1'b0 && t < 100) begin
         step();
         t++;
      end
      check({name, "_busy_fall_cycles"}, t, exp_cycles);
   endtask

   task automatic check_frame(input string name, input int idx, input logic [7:0] exp_bits);
      if (idx < frames.size()) begin
         check({name, "_bits"}, frames[idx].bits, exp_bits);
         check({name, "_cs_low_len"}, frames[idx].len, 66);
         check({name, "_bit_stable"}, frames[idx].stab, 0);
         check({name, "_done_at_end"}, frames[idx].done, 1'b1);
      end
   endtask

   vec_t vt[6];

   initial begin
      int         d0;
      int         idx;
      int         first_block;
      int         t;
      logic       rdy;
      logic [7:0] list[7];

      vt[0] = '{data: 8'hA5, exp_bits: 8'b1010_0101, exp_msb: 1'b1};
      vt[1] = '{data: 8'h01, exp_bits: 8'b0000_0001, exp_msb: 1'b0};
      vt[2] = '{data: 8'h80, exp_bits: 8'b1000_0000, exp_msb: 1'b1};
      vt[3] = '{data: 8'hFF, exp_bits: 8'b1111_1111, exp_msb: 1'b1};
      vt[4] = '{data: 8'h00, exp_bits: 8'b0000_0000, exp_msb: 1'b0};
      vt[5] = '{data: 8'h3C, exp_bits: 8'b0011_1100, exp_msb: 1'b0};

      // Reset values
      reset    = 1'b1;
      wr_valid = 1'b0;
      flush    = 1'b0;
      wr_data  = 'x;
      step();
      step();
      check("rst_cs_out", cs_out, 1'b1);
      check("rst_data_out", data_out, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_frame_count", frame_count, 16'h0000);
      check("rst_busy", busy, 1'b0);
      reset = 1'b0;
      step();
      check("rst_wr_ready", wr_ready, 1'b1);

      // Table: one byte at a time into an idle sequencer
      for (int i = 0; i < 6; i++) begin
         d0 = done_cnt;
         push1(vt[i].data);
         check($sformatf("vec%0d_cs_n1", i), cs_out, 1'b1);
         check($sformatf("vec%0d_busy_n1", i), busy, 1'b1);
         step();
         check($sformatf("vec%0d_cs_n2", i), cs_out, 1'b0);
         check($sformatf("vec%0d_msb_n2", i), data_out, vt[i].exp_msb);
         wait_frames($sformatf("vec%0d", i), i + 1, 200);
         check_frame($sformatf("vec%0d", i), i, vt[i].exp_bits);
         check($sformatf("vec%0d_count", i), frame_count, i + 1);
         wait_idle($sformatf("vec%0d", i), 4);
         check($sformatf("vec%0d_done_pulses", i), done_cnt - d0, 1);
      end

      // Three bytes back-to-back
      do_reset();
      d0 = done_cnt;
      push1(8'h01);
      push1(8'h80);
      push1(8'hFF);
      wait_frames("b2b", 3, 400);
      check_frame("b2b0", 0, 8'h01);
      check_frame("b2b1", 1, 8'h80);
      check_frame("b2b2", 2, 8'hFF);
      if (frames.size() >= 3) begin
         check("b2b_gap1", frames[1].gap, 5);
         check("b2b_gap2", frames[2].gap, 5);
      end
      check("b2b_count", frame_count, 16'd3);
      wait_idle("b2b", 4);
      check("b2b_done_pulses", done_cnt - d0, 3);

      // Six bytes held against a full FIFO while the first frame shifts
      do_reset();
      list = '{8'hC3, 8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
      push1(list[0]);
      wait_cs_low("hold");
      idx         = 1;
      first_block = -1;
      t           = 0;
      while (idx < 7 && t < 1000) begin
         wr_valid = 1'b1;
         wr_data  = list[idx];
         #1;
         rdy = wr_ready;
         if (!rdy && first_block < 0) first_block = idx - 1;
         step();
         t++;
         if (rdy) idx++;
      end
      wr_valid = 1'b0;
      wr_data  = 'x;
      check("hold_queued_before_block", first_block, 4);
      check("hold_all_accepted", idx, 7);
      wait_frames("hold", 7, 800);
      for (int i = 0; i < 7; i++) check_frame($sformatf("hold%0d", i), i, list[i]);
      check("hold_count", frame_count, 16'd7);
      wait_idle("hold", 4);
      check("hold_wr_ready_end", wr_ready, 1'b1);

      // Asynchronous reset in the middle of a frame
      do_reset();
      d0 = done_cnt;
      push1(8'hFF);
      wait_cs_low("arst");
      repeat (30) step();
      check("arst_data_before", data_out, 1'b1);
      #1 reset = 1'b1;
      #1;
      check("arst_cs_async", cs_out, 1'b1);
      check("arst_data_async", data_out, 1'b0);
      check("arst_count_async", frame_count, 16'h0000);
      step();
      reset = 1'b0;
      step();
      check("arst_busy", busy, 1'b0);
      check("arst_wr_ready", wr_ready, 1'b1);
      repeat (80) step();
      check("arst_no_frames", frames.size(), 0);
      check("arst_no_done", done_cnt - d0, 0);
      check("arst_count", frame_count, 16'h0000);
      push1(8'h5A);
      wait_frames("arst_new", 1, 200);
      check_frame("arst_new", 0, 8'h5A);
      check("arst_new_count", frame_count, 16'd1);
      wait_idle("arst_new", 4);

      // Flush while the first of three queued bytes is in flight
      do_reset();
      push1(8'h11);
      push1(8'h22);
      push1(8'h33);
      wait_cs_low("flush");
      repeat (10) step();
      flush    = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'h99;
      #1;
      check("flush_wr_ready_low", wr_ready, 1'b0);
      step();
      flush    = 1'b0;
      wr_valid = 1'b0;
      wr_data  = 'x;
      check("flush_busy_in_flight", busy, 1'b1);
      wait_frames("flush", 1, 200);
      check_frame("flush0", 0, 8'h11);
      wait_idle("flush", 4);
      repeat (100) step();
      check("flush_only_one_frame", frames.size(), 1);
      check("flush_count", frame_count, 16'd1);

      // Flush on the same edge as an IDLE pop: the head byte still goes out
      do_reset();
      push1(8'hA1);
      push1(8'hB2);
      push1(8'hC3);
      wait_frames("fpop_first", 1, 200);
      repeat (4) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      wait_frames("fpop_second", 2, 200);
      check_frame("fpop1", 1, 8'hB2);
      if (frames.size() >= 2) check("fpop_gap", frames[1].gap, 5);
      wait_idle("fpop", 4);
      repeat (100) step();
      check("fpop_no_third", frames.size(), 2);
      check("fpop_count", frame_count, 16'd2);

      // frame_count wrap
      do_reset();
      force dut.frame_count = 16'hFFFF;
      step();
      release dut.frame_count;
      step();
      check("wrap_preload", frame_count, 16'hFFFF);
      d0 = done_cnt;
      push1(8'h3C);
      wait_frames("wrap", 1, 200);
      check_frame("wrap", 0, 8'h3C);
      check("wrap_count", frame_count, 16'h0000);
      check("wrap_done_pulses", done_cnt - d0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
